spi_sd_master: RTL and testbench

- Byte-wide SPI master for the SD-card slot, mapped into Z80 I/O space.
- Replaces the bit-banged sd_clk/sd_mosi/sd_ssel_n GPIO path: the CPU writes a byte, the block shifts it out in SPI mode 0 and captures the reply byte.
- Sits between the board's I/O decode (tick strobes, addressed register select) and the SD pins; its read mux feeds the board's CPU data-bus output mux.

---
 rtl/spi_sd_pkg.sv | 33 +++
 rtl/spi_sd_shifter.sv | 97 +++++++++
 rtl/spi_sd_master.sv | 118 +++++++++++
 tb/tb_spi_sd_master.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sd_pkg.sv
// Shared register map, status layout and FSM encoding for the SD-card SPI master.
package spi_sd_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_CTRL = 2'd1;
    localparam logic [1:0] REG_DIV  = 2'd2;

    localparam int unsigned STAT_BUSY  = 7;
    localparam int unsigned STAT_OVR   = 6;
    localparam int unsigned STAT_DONE  = 5;
    localparam int unsigned STAT_IRQEN = 1;
    localparam int unsigned STAT_SSEL  = 0;

    localparam int unsigned CTRL_CLR_OVR = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;

    function automatic logic [7:0] status_word(input logic busy, input logic ovr,
                                               input logic done, input logic irq_en,
                                               input logic ssel);
        logic [7:0] s;
        s             = 8'h00;
        s[STAT_BUSY]  = busy;
        s[STAT_OVR]   = ovr;
        s[STAT_DONE]  = done;
        s[STAT_IRQEN] = irq_en;
        s[STAT_SSEL]  = ssel;
        return s;
    endfunction

endpackage

// File: rtl/spi_sd_shifter.sv
// SPI mode-0 byte shifter: half-period divider, bit counter, shift register and pin drive.
module spi_sd_shifter
    import spi_sd_pkg::*;
(
    input  logic       phi,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic [7:0] div,
    input  logic       miso,
    output logic       busy,
    output logic [7:0] rx_byte,
    output logic       done,
    output logic       sclk,
    output logic       mosi
);

    logic [1:0] state_q;
    logic [7:0] hc_q;
    logic [2:0] bc_q;
    logic [7:0] shreg_q;
    logic       miso_q;
    logic [7:0] rx_q;
    logic       sclk_q;
    logic       mosi_q;
    logic       busy_q;
    logic       half_end;
    logic [7:0] shifted;

    assign half_end = (hc_q == div);
    // Bit sampled on the rising edge enters the bottom as the byte moves up on the fall.
    assign shifted  = {shreg_q[6:0], miso_q};
    assign done     = (state_q == ST_HIGH) && half_end && (bc_q == 3'd7);

    always_ff @(posedge phi or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hc_q    <= 8'd0;
            bc_q    <= 3'd0;
            shreg_q <= 8'd0;
            miso_q  <= 1'b0;
            rx_q    <= 8'hFF;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        shreg_q <= tx_byte;
                        mosi_q  <= tx_byte[7];
                        bc_q    <= 3'd0;
                        hc_q    <= 8'd0;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (half_end) begin
                        sclk_q  <= 1'b1;
                        miso_q  <= miso;
                        hc_q    <= 8'd0;
                        state_q <= ST_HIGH;
                    end else begin
                        hc_q <= hc_q + 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (half_end) begin
                        sclk_q  <= 1'b0;
                        hc_q    <= 8'd0;
                        shreg_q <= shifted;
                        if (bc_q == 3'd7) begin
                            rx_q    <= shifted;
                            busy_q  <= 1'b0;
                            mosi_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            mosi_q  <= shreg_q[6];
                            bc_q    <= bc_q + 3'd1;
                            state_q <= ST_LOW;
                        end
                    end else begin
                        hc_q <= hc_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign rx_byte = rx_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;

endmodule

// File: rtl/spi_sd_master.sv
// Z80 I/O-mapped SD-card SPI master: DATA/CTRL/DIV registers, read mux and optional irq.
// Build with SPI_IRQ_EN defined to get the interrupt output and CTRL irq_en bit.
module spi_sd_master
    import spi_sd_pkg::*;
#(
    parameter logic [7:0] DIV_RESET = 8'd11
) (
    input  logic       phi,
    input  logic       reset,
    input  logic [1:0] reg_sel,
    input  logic       wr_tick,
    input  logic       rd_tick,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       sd_miso,
    output logic       sd_clk,
    output logic       sd_mosi,
    output logic       sd_ssel_n,
    output logic       busy,
    output logic       irq
);

    logic [7:0] div_q;
    logic       ssel_q;
    logic       ovr_q;
    logic       done_q;
    logic       irq_en;
    logic       start;
    logic       xfer_done;
    logic       data_rd;
    logic       ctrl_wr;
    logic [7:0] rx_byte;

    assign start   = wr_tick && (reg_sel == REG_DATA) && !busy;
    assign data_rd = rd_tick && (reg_sel == REG_DATA);
    assign ctrl_wr = wr_tick && (reg_sel == REG_CTRL);

    spi_sd_shifter u_shifter (
        .phi     (phi),
        .reset   (reset),
        .start   (start),
        .tx_byte (din),
        .div     (div_q),
        .miso    (sd_miso),
        .busy    (busy),
        .rx_byte (rx_byte),
        .done    (xfer_done),
        .sclk    (sd_clk),
        .mosi    (sd_mosi)
    );

    always_ff @(posedge phi or posedge reset) begin
        if (reset) begin
            div_q  <= DIV_RESET;
            ssel_q <= 1'b0;
            ovr_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (wr_tick) begin
                case (reg_sel)
                    REG_DATA: if (busy) ovr_q <= 1'b1;
                    REG_CTRL: begin
                        ssel_q <= din[STAT_SSEL];
                        if (din[CTRL_CLR_OVR]) ovr_q <= 1'b0;
                    end
                    REG_DIV:  if (!busy) div_q <= din;
                    default:  ;
                endcase
            end
            // A completing transfer outranks a simultaneous DATA read clearing done.
            if (start) begin
                done_q <= 1'b0;
            end else if (xfer_done) begin
                done_q <= 1'b1;
            end else if (data_rd) begin
                done_q <= 1'b0;
            end
        end
    end

`ifdef SPI_IRQ_EN
    logic irq_en_q;
    logic irq_q;

    always_ff @(posedge phi or posedge reset) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_q <= din[STAT_IRQEN];
            if (xfer_done && irq_en_q) begin
                irq_q <= 1'b1;
            end else if (data_rd || (ctrl_wr && !din[STAT_IRQEN])) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign irq_en = irq_en_q;
    assign irq    = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        dout = 8'h00;
        case (reg_sel)
            REG_DATA: dout = rx_byte;
            REG_CTRL: dout = status_word(busy, ovr_q, done_q, irq_en, ssel_q);
            REG_DIV:  dout = div_q;
            default:  dout = 8'h00;
        endcase
    end

    assign sd_ssel_n = ~ssel_q;

endmodule

// File: tb/tb_spi_sd_master.sv
// Self-checking bench for spi_sd_master: vector table, random transfers, overrun and reset cases.
module tb_spi_sd_master;

`ifdef SPI_IRQ_EN
    localparam bit HasIrq = 1'b1;
`else
    localparam bit HasIrq = 1'b0;
`endif

    localparam logic [1:0] SelData = 2'd0;
    localparam logic [1:0] SelCtrl = 2'd1;
    localparam logic [1:0] SelDiv  = 2'd2;
    localparam logic [1:0] SelRsvd = 2'd3;

    logic       phi = 1'b0;
    logic       reset;
    logic [1:0] reg_sel;
    logic       wr_tick;
    logic       rd_tick;
    logic [7:0] din;
    logic [7:0] dout;
    logic       sd_miso;
    logic       sd_clk;
    logic       sd_mosi;
    logic       sd_ssel_n;
    logic       busy;
    logic       irq;

    logic       loop_en;
    logic [7:0] miso_byte;
    logic [2:0] miso_idx;

    int checks = 0;
    int errors = 0;

    logic       ssel_m;
    logic       irqen_m;
    logic [7:0] div_m;

    typedef struct packed {
        logic [7:0] tx;
        logic [7:0] div;
        logic       loop;
        logic [7:0] miso;
        logic [7:0] exp_rx;
        int         cyc;
    } vec_t;

    vec_t vecs[5];

    assign sd_miso = loop_en ? sd_mosi : miso_byte[miso_idx];

    always #5 phi = ~phi;

    spi_sd_master dut (
        .phi       (phi),
        .reset     (reset),
        .reg_sel   (reg_sel),
        .wr_tick   (wr_tick),
        .rd_tick   (rd_tick),
        .din       (din),
        .dout      (dout),
        .sd_miso   (sd_miso),
        .sd_clk    (sd_clk),
        .sd_mosi   (sd_mosi),
        .sd_ssel_n (sd_ssel_n),
        .busy      (busy),
        .irq       (irq)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic checkint(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] data);
        @(negedge phi);
        reg_sel = sel;
        din     = data;
        wr_tick = 1'b1;
        @(negedge phi);
        wr_tick = 1'b0;
    endtask

    task automatic rd(input logic [1:0] sel, output logic [7:0] v);
        @(negedge phi);
        reg_sel = sel;
        rd_tick = 1'b1;
        #1 v = dout;
        @(negedge phi);
        rd_tick = 1'b0;
    endtask

    function automatic logic [7:0] exp_status(input logic b, input logic o, input logic d);
        return {b, o, d, 3'b000, irqen_m, ssel_m};
    endfunction

    // One full byte transfer; inj > 0 issues a DATA write of 8'h12 at that busy cycle.
    task automatic xfer(input string name, input logic [7:0] tx, input logic [7:0] div,
                        input logic loop, input logic [7:0] miso, input logic [7:0] exp_rx,
                        input int exp_cyc, input int inj);
        int         cnt;
        int         pulses;
        int         hw;
        logic       prev;
        logic       irq_any;
        logic [7:0] mosi_seen;
        logic [7:0] v;
        if (div !== div_m) begin
            wr(SelDiv, div);
            div_m = div;
        end
        loop_en   = loop;
        miso_byte = miso;
        miso_idx  = 3'd7;
        wr(SelData, tx);
        cnt       = 0;
        pulses    = 0;
        hw        = 0;
        prev      = 1'b0;
        irq_any   = 1'b0;
        mosi_seen = 8'h00;
        while (busy === 1'b1 && cnt < 5000) begin
            cnt++;
            reg_sel = SelData;
            din     = 8'h12;
            wr_tick = (cnt == inj);
            if (sd_clk && !prev) begin
                pulses++;
                mosi_seen = {mosi_seen[6:0], sd_mosi};
            end
            if (!sd_clk && prev) miso_idx = miso_idx - 3'd1;
            if (sd_clk && pulses == 1) hw++;
            irq_any = irq_any | irq;
            prev    = sd_clk;
            @(negedge phi);
        end
        wr_tick = 1'b0;
        checkint({name, " busy_cycles"}, cnt, exp_cyc);
        checkint({name, " clk_pulses"}, pulses, 8);
        checkint({name, " half_period"}, hw, int'(div) + 1);
        check8({name, " mosi_bits"}, mosi_seen, tx);
        check8({name, " irq_during"}, {7'd0, irq_any}, 8'h00);
        check8({name, " idle_pins"}, {6'd0, sd_clk, sd_mosi}, 8'h01);
        rd(SelCtrl, v);
        check8({name, " status_done"}, v, exp_status(1'b0, inj > 0, 1'b1));
        check8({name, " irq_after"}, {7'd0, irq}, {7'd0, HasIrq && irqen_m});
        if (inj > 0) begin
            wr(SelCtrl, {1'b0, 1'b1, 4'b0000, irqen_m, ssel_m});
            rd(SelCtrl, v);
            check8({name, " ovr_clear"}, v, exp_status(1'b0, 1'b0, 1'b1));
        end
        rd(SelData, v);
        check8({name, " rx"}, v, exp_rx);
        rd(SelCtrl, v);
        check8({name, " done_clear"}, v, exp_status(1'b0, 1'b0, 1'b0));
        check8({name, " irq_clear"}, {7'd0, irq}, 8'h00);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;
        logic [7:0] tx;
        logic [7:0] dv;
        logic [7:0] mi;
        logic       lp;
        logic       b;
        int         cyc;
        int         inj;
        int         rises;
        int         cnt;
        logic       prev;

        vecs[0] = '{8'hA5, 8'd0, 1'b1, 8'h00, 8'hA5, 16};
        vecs[1] = '{8'hFF, 8'd3, 1'b0, 8'h00, 8'h00, 64};
        vecs[2] = '{8'h3C, 8'd1, 1'b0, 8'hC3, 8'hC3, 32};
        vecs[3] = '{8'h00, 8'd2, 1'b0, 8'hFF, 8'hFF, 48};
        vecs[4] = '{8'h81, 8'd0, 1'b0, 8'h7E, 8'h7E, 16};

        reset     = 1'b1;
        reg_sel   = 2'd0;
        wr_tick   = 1'b0;
        rd_tick   = 1'b0;
        din       = 8'h00;
        loop_en   = 1'b0;
        miso_byte = 8'hFF;
        miso_idx  = 3'd7;
        ssel_m    = 1'b0;
        irqen_m   = 1'b0;
        div_m     = 8'd11;
        repeat (3) @(negedge phi);
        reset = 1'b0;

        check8("reset_pins", {4'd0, sd_ssel_n, sd_mosi, sd_clk, busy}, 8'h0C);
        check8("reset_irq", {7'd0, irq}, 8'h00);
        rd(SelCtrl, v);
        check8("reset_status", v, 8'h00);
        rd(SelDiv, v);
        check8("reset_div", v, 8'd11);
        rd(SelData, v);
        check8("reset_rx", v, 8'hFF);
        rd(SelRsvd, v);
        check8("reserved_read", v, 8'h00);
        wr(SelRsvd, 8'hAA);
        rd(SelDiv, v);
        check8("reserved_write", v, 8'd11);

        for (int i = 0; i < 5; i++) begin
            xfer($sformatf("vec%0d", i), vecs[i].tx, vecs[i].div, vecs[i].loop,
                 vecs[i].miso, vecs[i].exp_rx, vecs[i].cyc, -1);
        end

        // Overrun: DATA write mid-transfer must not disturb the byte in flight.
        xfer("overrun", 8'h96, 8'd1, 1'b1, 8'h00, 8'h96, 32, 9);

        // irq enable path (irq must stay 0 when the feature is absent).
        wr(SelCtrl, 8'h03);
        ssel_m  = 1'b1;
        irqen_m = HasIrq;
        check8("ssel_on", {7'd0, sd_ssel_n}, 8'h00);
        xfer("irq_en", 8'h5A, 8'd0, 1'b0, 8'h33, 8'h33, 16, -1);
        wr(SelCtrl, 8'h01);
        irqen_m = 1'b0;
        xfer("irq_dis", 8'hC6, 8'd0, 1'b0, 8'h6C, 8'h6C, 16, -1);

        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                b      = 1'($urandom_range(0, 1));
                ssel_m = 1'($urandom_range(0, 1));
                wr(SelCtrl, {6'd0, b, ssel_m});
                irqen_m = HasIrq ? b : 1'b0;
                check8($sformatf("rnd%0d ssel", i), {7'd0, sd_ssel_n}, {7'd0, ~ssel_m});
            end
            tx  = 8'($urandom);
            dv  = 8'($urandom_range(0, 4));
            lp  = ($urandom_range(0, 3) == 0);
            mi  = 8'($urandom);
            cyc = 16 * (int'(dv) + 1);
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, cyc)) : -1;
            xfer($sformatf("rnd%0d", i), tx, dv, lp, mi, lp ? tx : mi, cyc, inj);
        end

        // Reset in the middle of bit 4 while the card is selected.
        wr(SelCtrl, 8'h01);
        ssel_m = 1'b1;
        wr(SelDiv, 8'd1);
        div_m   = 8'd1;
        loop_en = 1'b1;
        wr(SelData, 8'h5A);
        rises = 0;
        cnt   = 0;
        prev  = 1'b0;
        while (rises < 5 && cnt < 500) begin
            if (sd_clk && !prev) rises++;
            prev = sd_clk;
            cnt++;
            if (rises < 5) @(negedge phi);
        end
        checkint("midrst_reach", rises, 5);
        check8("midrst_clk_high", {7'd0, sd_clk}, 8'h01);
        reset = 1'b1;
        #1;
        check8("midrst_pins", {4'd0, sd_ssel_n, sd_mosi, sd_clk, busy}, 8'h0C);
        check8("midrst_irq", {7'd0, irq}, 8'h00);
        @(negedge phi);
        reset   = 1'b0;
        ssel_m  = 1'b0;
        irqen_m = 1'b0;
        div_m   = 8'd11;
        rd(SelCtrl, v);
        check8("midrst_status", v, 8'h00);
        rd(SelDiv, v);
        check8("midrst_div", v, 8'd11);
        rd(SelData, v);
        check8("midrst_rx", v, 8'hFF);
        xfer("post_rst", 8'h3C, 8'd1, 1'b0, 8'h96, 8'h96, 32, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
